// File: rtl/eu_speriph_plug_arbiter.sv
// Round-robin merge of NB_PLUGS peripheral plugs onto the event-unit slave port, with a
// grant-order FIFO steering responses back. Optional conflict counter: EU_PLUG_ARB_STATS_EN.
module eu_speriph_plug_arbiter #(
    parameter int NB_PLUGS  = 2,
    parameter int ID_WIDTH  = 5,
    parameter int MAX_OUTST = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_PLUGS-1:0]                s_req_i,
    input  logic [NB_PLUGS-1:0][31:0]          s_add_i,
    input  logic [NB_PLUGS-1:0]                s_wen_i,
    input  logic [NB_PLUGS-1:0][31:0]          s_wdata_i,
    input  logic [NB_PLUGS-1:0][3:0]           s_be_i,
    input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  s_id_i,
    output logic [NB_PLUGS-1:0]                s_gnt_o,
    output logic [NB_PLUGS-1:0]                s_r_valid_o,
    output logic [NB_PLUGS-1:0]                s_r_opc_o,
    output logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  s_r_id_o,
    output logic [NB_PLUGS-1:0][31:0]          s_r_rdata_o,
    output logic                               m_req_o,
    output logic [31:0]                        m_add_o,
    output logic                               m_wen_o,
    output logic [31:0]                        m_wdata_o,
    output logic [3:0]                         m_be_o,
    output logic [ID_WIDTH-1:0]                m_id_o,
    input  logic                               m_gnt_i,
    input  logic                               m_r_valid_i,
    input  logic                               m_r_opc_i,
    input  logic [ID_WIDTH-1:0]                m_r_id_i,
    input  logic [31:0]                        m_r_rdata_i,
    output logic                               orphan_rsp_o
`ifdef EU_PLUG_ARB_STATS_EN
    ,
    output logic [31:0]                        conflict_cnt_o
`endif
);

    localparam int IW = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [IW-1:0] r_rrPtr;
    logic          r_locked;
    logic [IW-1:0] r_lockIdx;
    logic [IW-1:0] r_fifo [MAX_OUTST];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [OW-1:0] r_occ;
    logic          r_orphan;

    logic [IW-1:0] w_winner;
    logic          w_found;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    // A plug left waiting on m_gnt_i stays locked as winner so a newly raised
    // request ahead of it in round-robin order cannot steal the slot.
    always_comb begin
        w_winner = r_rrPtr;
        w_found  = 1'b0;
        for (int k = 0; k < NB_PLUGS; k++) begin
            automatic int idx = (int'(r_rrPtr) + k) % NB_PLUGS;
            if (!w_found && s_req_i[idx]) begin
                w_winner = IW'(idx);
                w_found  = 1'b1;
            end
        end
        if (r_locked && s_req_i[r_lockIdx]) begin
            w_winner = r_lockIdx;
        end
    end

    // A response arriving while full frees a slot in the same cycle, so push is allowed.
    assign w_full  = (r_occ == OW'(MAX_OUTST));
    assign w_empty = (r_occ == '0);
    assign w_pop   = m_r_valid_i & ~w_empty;
    assign m_req_o = (|s_req_i) & (~w_full | m_r_valid_i);
    assign w_push  = m_req_o & m_gnt_i;

    assign m_add_o   = s_add_i[w_winner];
    assign m_wen_o   = s_wen_i[w_winner];
    assign m_wdata_o = s_wdata_i[w_winner];
    assign m_be_o    = s_be_i[w_winner];
    assign m_id_o    = s_id_i[w_winner];

    assign s_r_opc_o   = {NB_PLUGS{m_r_opc_i}};
    assign s_r_id_o    = {NB_PLUGS{m_r_id_i}};
    assign s_r_rdata_o = {NB_PLUGS{m_r_rdata_i}};
    assign orphan_rsp_o = r_orphan;

    always_comb begin
        s_gnt_o     = '0;
        s_r_valid_o = '0;
        if (w_push) begin
            s_gnt_o[w_winner] = 1'b1;
        end
        if (w_pop) begin
            s_r_valid_o[r_fifo[r_rdPtr]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rrPtr   <= '0;
            r_locked  <= 1'b0;
            r_lockIdx <= '0;
        end else if (w_push) begin
            r_rrPtr  <= (w_winner == IW'(NB_PLUGS - 1)) ? '0 : w_winner + 1'b1;
            r_locked <= 1'b0;
        end else if (m_req_o) begin
            r_locked  <= 1'b1;
            r_lockIdx <= w_winner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= w_winner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_occ    <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == PW'(MAX_OUTST - 1)) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == PW'(MAX_OUTST - 1)) ? '0 : r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 1'b1;
            end
            if (m_r_valid_i && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

`ifdef EU_PLUG_ARB_STATS_EN
    logic [31:0] r_conflictCnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_conflictCnt <= '0;
        end else if (($countones(s_req_i) >= 2) && (r_conflictCnt != 32'hFFFF_FFFF)) begin
            r_conflictCnt <= r_conflictCnt + 32'd1;
        end
    end

    assign conflict_cnt_o = r_conflictCnt;
`endif

endmodule

// File: tb/tb_eu_speriph_plug_arbiter.sv
// Scoreboard bench for eu_speriph_plug_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_eu_speriph_plug_arbiter;

    localparam int NP  = 2;
    localparam int IDW = 5;
    localparam int MO  = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NP-1:0]             sReq;
    logic [NP-1:0][31:0]       sAdd;
    logic [NP-1:0]             sWen;
    logic [NP-1:0][31:0]       sWdata;
    logic [NP-1:0][3:0]        sBe;
    logic [NP-1:0][IDW-1:0]    sId;
    logic [NP-1:0]             sGnt;
    logic [NP-1:0]             sRValid;
    logic [NP-1:0]             sROpc;
    logic [NP-1:0][IDW-1:0]    sRId;
    logic [NP-1:0][31:0]       sRRdata;
    logic                      mReq;
    logic [31:0]               mAdd;
    logic                      mWen;
    logic [31:0]               mWdata;
    logic [3:0]                mBe;
    logic [IDW-1:0]            mId;
    logic                      mGnt;
    logic                      mRValid;
    logic                      mROpc;
    logic [IDW-1:0]            mRId;
    logic [31:0]               mRRdata;
    logic                      orphan;
`ifdef EU_PLUG_ARB_STATS_EN
    logic [31:0]               conflictCnt;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        int              plug;
        logic [31:0]     rdata;
        logic [IDW-1:0]  id;
        logic            opc;
    } rsp_t;

    rsp_t sbq[$];
    int   mq[$];
    int   mRr = 0;
    int   mPending = -1;
    bit   mOrphan = 1'b0;

    eu_speriph_plug_arbiter #(.NB_PLUGS(NP), .ID_WIDTH(IDW), .MAX_OUTST(MO)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_req_i(sReq), .s_add_i(sAdd), .s_wen_i(sWen), .s_wdata_i(sWdata),
        .s_be_i(sBe), .s_id_i(sId), .s_gnt_o(sGnt), .s_r_valid_o(sRValid),
        .s_r_opc_o(sROpc), .s_r_id_o(sRId), .s_r_rdata_o(sRRdata),
        .m_req_o(mReq), .m_add_o(mAdd), .m_wen_o(mWen), .m_wdata_o(mWdata),
        .m_be_o(mBe), .m_id_o(mId), .m_gnt_i(mGnt), .m_r_valid_i(mRValid),
        .m_r_opc_i(mROpc), .m_r_id_i(mRId), .m_r_rdata_i(mRRdata),
        .orphan_rsp_o(orphan)
`ifdef EU_PLUG_ARB_STATS_EN
        , .conflict_cnt_o(conflictCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [NP-1:0] req, input logic gnt, input logic rv, input logic r);
        rst  = r;
        sReq = req;
        mGnt = gnt;
        mRValid = rv;
        for (int p = 0; p < NP; p++) begin
            sAdd[p]   = $urandom;
            sWdata[p] = $urandom;
            sWen[p]   = 1'($urandom);
            sBe[p]    = 4'($urandom);
            sId[p]    = IDW'($urandom);
        end
        mROpc   = 1'($urandom);
        mRId    = IDW'($urandom);
        mRRdata = $urandom;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NP-1:0] req, input logic gnt, input logic rv, input logic r);
        drive(req, gnt, rv, r);
        step();
    endtask

    // Reference model: the outstanding transactions are a plain queue of plug numbers.
    task automatic modelCycle();
        int  winner;
        bit  popOk;
        bit  expReq;
        logic [NP-1:0] expGnt;
        winner = -1;
        popOk  = mRValid && (mq.size() > 0);
        expReq = (sReq != '0) && ((mq.size() < MO) || popOk);
        if (mPending >= 0 && sReq[mPending]) begin
            winner = mPending;
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (winner < 0 && sReq[(mRr + k) % NP]) winner = (mRr + k) % NP;
            end
        end
        expGnt = '0;
        if (expReq && mGnt) expGnt[winner] = 1'b1;
        checkOutput("m_req", mReq, expReq);
        checkOutput("s_gnt", sGnt, expGnt);
        checkOutput("orphan", orphan, mOrphan);
        if (expReq) begin
            checkOutput("m_add", mAdd, sAdd[winner]);
            checkOutput("m_wdata", mWdata, sWdata[winner]);
            checkOutput("m_id", mId, sId[winner]);
            checkOutput("m_wen_be", {mWen, mBe}, {sWen[winner], sBe[winner]});
        end
        if (popOk) sbq.push_back('{plug: mq[0], rdata: mRRdata, id: mRId, opc: mROpc});
        if (rst) begin
            mq.delete();
            mRr = 0;
            mPending = -1;
            mOrphan = 1'b0;
        end else begin
            if (mRValid && mq.size() == 0) mOrphan = 1'b1;
            if (popOk) void'(mq.pop_front());
            if (expReq && mGnt) begin
                mq.push_back(winner);
                mRr = (winner + 1) % NP;
                mPending = -1;
            end else if (expReq) begin
                mPending = winner;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            modelCycle();
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        rsp_t e;
        logic [NP-1:0] expV;
        forever begin
            @(negedge clk);
            #1;
            if (sRValid !== '0) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_rsp", sRValid, '0);
                end else begin
                    e = sbq.pop_front();
                    expV = '0;
                    expV[e.plug] = 1'b1;
                    checkOutput("rsp_valid", sRValid, expV);
                    checkOutput("rsp_rdata", sRRdata, {NP{e.rdata}});
                    checkOutput("rsp_id", sRId, {NP{e.id}});
                    checkOutput("rsp_opc", sROpc, {NP{e.opc}});
                end
            end
        end
    end

    initial begin
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_m_req", mReq, 1'b0);
        checkOutput("reset_s_gnt", sGnt, 2'b00);
        checkOutput("reset_r_valid", sRValid, 2'b00);
        checkOutput("reset_orphan", orphan, 1'b0);
        step();

        // single plug 0 read, response next cycle
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        checkOutput("single_gnt", sGnt, 2'b01);
        step();
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("single_rvalid", sRValid, 2'b01);
        checkOutput("single_rdata", sRRdata[0], mRRdata);
        step();

        // both plugs every cycle alternate grants
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        checkOutput("rr_gnt0", sGnt, 2'b01);
        step();
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        checkOutput("rr_gnt1", sGnt, 2'b10);
        step();
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        checkOutput("rr_gnt2", sGnt, 2'b01);
        step();
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        checkOutput("rr_gnt3", sGnt, 2'b10);
        step();
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);

        // FIFO full stall, granted on push+pop
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b0, 1'b0);
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        checkOutput("full_m_req", mReq, 1'b0);
        checkOutput("full_s_gnt", sGnt, 2'b00);
        step();
        drive(2'b01, 1'b1, 1'b1, 1'b0);
        checkOutput("pushpop_gnt", sGnt, 2'b01);
        checkOutput("pushpop_rvalid", sRValid, 2'b01);
        step();
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);

        // waiting winner is not preempted
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(2'b10, 1'b0, 1'b0, 1'b0);
        drive(2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_add", mAdd, sAdd[1]);
        step();
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_gnt", sGnt, 2'b10);
        step();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);

        // reset flushes FIFO, late response is orphaned
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("orphan_no_valid", sRValid, 2'b00);
        step();
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("orphan_sticky", orphan, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("orphan_cleared", orphan, 1'b0);
        step();

`ifdef EU_PLUG_ARB_STATS_EN
        for (int i = 0; i < 5; i++) applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("conflict_cnt", conflictCnt, 32'd5);
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(NP'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 10 && mq.size() > 0; i++) applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
